// File: rtl/orb_frame_former.sv
// orb_frame_former: reads telemetry words from a buffer and serialises them MSB first at a selectable bit rate,
// marking frame starts and counting frames within a group cycle.
module orb_frame_former #(
    parameter int WORD_W      = 12,
    parameter int ADDR_W      = 11,
    parameter int FRAME_WORDS = 2048,
    parameter int GRP_W       = 5,
    parameter int NUM_GROUPS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iEnable,
    input  logic [2:0]        iMode,
    input  logic [WORD_W-1:0] iWord,
    output logic              oRdEn,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oOrbit,
    output logic              oFrameStart,
    output logic [GRP_W-1:0]  oNumGrp,
    output logic              oGrpOddity,
    output logic              oBusy
);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t            state_q, state_d;
    logic [2:0]        m_q, m_d, m_sel;
    logic [3:0]        per_q, per_d, last_per;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ADDR_W-1:0] wrd_q, wrd_d, addr_q, addr_d, nxt_wrd;
    logic [WORD_W-1:0] sh_q, sh_d, shadow_q, shadow_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic              rd_en_q, rd_en_d, rd_pend_q, rd_pend_d;
    logic              orbit_q, orbit_d, fs_q, fs_d, busy_q, busy_d;
    logic              bit_end, word_end, frame_end;

    assign m_sel     = (iMode > 3'd4) ? 3'd4 : iMode;
    // 1 << 4 wraps to 0 in four bits, so P = 16 still yields a last count of 15
    assign last_per  = (4'd1 << m_q) - 4'd1;
    assign bit_end   = per_q == last_per;
    assign word_end  = bit_end && (bit_q == BIT_W'(WORD_W - 1));
    assign frame_end = word_end && (wrd_q == ADDR_W'(FRAME_WORDS - 1));
    assign nxt_wrd   = frame_end ? '0 : wrd_q + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        per_d     = per_q;
        bit_d     = bit_q;
        wrd_d     = wrd_q;
        addr_d    = addr_q;
        sh_d      = sh_q;
        grp_d     = grp_q;
        orbit_d   = orbit_q;
        rd_en_d   = 1'b0;
        fs_d      = 1'b0;
        rd_pend_d = rd_en_q;
        shadow_d  = rd_pend_q ? iWord : shadow_q;
        if (state_q == IDLE) begin
            orbit_d = 1'b0;
            if (iEnable) begin
                m_d     = m_sel;
                rd_en_d = 1'b1;
                addr_d  = '0;
                state_d = PRIME;
            end
        end else if (state_q == PRIME) begin
            if (rd_pend_q) begin
                sh_d    = iWord;
                orbit_d = iWord[WORD_W-1];
                per_d   = '0;
                bit_d   = '0;
                wrd_d   = '0;
                rd_en_d = 1'b1;
                addr_d  = ADDR_W'(1);
                fs_d    = 1'b1;
                state_d = RUN;
            end
        end else if (frame_end && !iEnable) begin
            // the prefetched address-0 word in the shadow is simply abandoned
            state_d = IDLE;
            orbit_d = 1'b0;
            addr_d  = '0;
            per_d   = '0;
            bit_d   = '0;
            wrd_d   = '0;
        end else if (word_end) begin
            sh_d    = shadow_q;
            orbit_d = shadow_q[WORD_W-1];
            per_d   = '0;
            bit_d   = '0;
            wrd_d   = nxt_wrd;
            rd_en_d = 1'b1;
            addr_d  = (nxt_wrd == ADDR_W'(FRAME_WORDS - 1)) ? '0 : nxt_wrd + ADDR_W'(1);
            fs_d    = frame_end;
            if (frame_end) begin
                m_d   = m_sel;
                grp_d = (grp_q == GRP_W'(NUM_GROUPS - 1)) ? '0 : grp_q + GRP_W'(1);
            end
        end else if (bit_end) begin
            sh_d    = sh_q << 1;
            orbit_d = sh_q[WORD_W-2];
            per_d   = '0;
            bit_d   = bit_q + BIT_W'(1);
        end else begin
            per_d = per_q + 4'd1;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            per_q     <= '0;
            bit_q     <= '0;
            wrd_q     <= '0;
            addr_q    <= '0;
            sh_q      <= '0;
            shadow_q  <= '0;
            grp_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            orbit_q   <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            per_q     <= per_d;
            bit_q     <= bit_d;
            wrd_q     <= wrd_d;
            addr_q    <= addr_d;
            sh_q      <= sh_d;
            shadow_q  <= shadow_d;
            grp_q     <= grp_d;
            rd_en_q   <= rd_en_d;
            rd_pend_q <= rd_pend_d;
            orbit_q   <= orbit_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end

    assign oRdEn       = rd_en_q;
    assign oAddr       = addr_q;
    assign oOrbit      = orbit_q;
    assign oFrameStart = fs_q;
    assign oNumGrp     = grp_q;
    assign oGrpOddity  = grp_q[0];
    assign oBusy       = busy_q;
endmodule

// File: tb/tb_orb_frame_former.sv
// tb_orb_frame_former: directed table-driven bench for the frame former with a 4-word, 4-bit frame.
module tb_orb_frame_former;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iEnable = 1'b0;
    logic [2:0] iMode = 3'd0;
    logic [3:0] iWord = 4'd0;
    logic       oRdEn, oOrbit, oFrameStart, oGrpOddity, oBusy;
    logic [1:0] oAddr;
    logic [0:0] oNumGrp;

    int checks = 0;
    int errors = 0;

    orb_frame_former #(.WORD_W(4), .ADDR_W(2), .FRAME_WORDS(4), .GRP_W(1), .NUM_GROUPS(2)) dut (
        .clk(clk), .reset(reset), .iEnable(iEnable), .iMode(iMode), .iWord(iWord),
        .oRdEn(oRdEn), .oAddr(oAddr), .oOrbit(oOrbit), .oFrameStart(oFrameStart),
        .oNumGrp(oNumGrp), .oGrpOddity(oGrpOddity), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
    always @(posedge clk) if (oRdEn) iWord <= mem[oAddr];

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic       orb, fs, rd;
        logic [1:0] addr;
        logic       grp, busy;
    } vec_t;

    vec_t tbl[40];
    int   n_vec = 0;

    task automatic add(input logic en, input logic [2:0] mode, input logic orb, input logic fs,
                       input logic rd, input logic [1:0] addr, input logic grp, input logic busy);
        tbl[n_vec] = '{en, mode, orb, fs, rd, addr, grp, busy};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!oFrameStart && n < 1000);
        if (!oFrameStart) chk("fs_timeout", 32'd0, 32'd1);
    endtask

    int n;

    initial begin
        // cycle-by-cycle expectations from the enable edge N through a stop after two frames
        add(1,0, 0,0,1,0,0,1); add(1,0, 0,0,0,0,0,1);
        add(1,0, 1,1,1,1,0,1); add(1,0, 0,0,0,0,0,1); add(1,0, 1,0,0,0,0,1); add(1,0, 0,0,0,0,0,1);
        add(1,0, 0,0,1,2,0,1); add(1,0, 1,0,0,0,0,1); add(1,0, 0,0,0,0,0,1); add(1,0, 1,0,0,0,0,1);
        add(1,0, 1,0,1,3,0,1); add(1,0, 1,0,0,0,0,1); add(1,0, 0,0,0,0,0,1); add(1,0, 0,0,0,0,0,1);
        add(1,0, 0,0,1,0,0,1); add(1,0, 0,0,0,0,0,1); add(1,0, 1,0,0,0,0,1); add(1,0, 1,0,0,0,0,1);
        add(1,0, 1,1,1,1,1,1); add(1,0, 0,0,0,0,1,1); add(1,0, 1,0,0,0,1,1); add(1,0, 0,0,0,0,1,1);
        add(1,0, 0,0,1,2,1,1); add(0,0, 1,0,0,0,1,1); add(0,0, 0,0,0,0,1,1); add(0,0, 1,0,0,0,1,1);
        add(0,0, 1,0,1,3,1,1); add(0,0, 1,0,0,0,1,1); add(0,0, 0,0,0,0,1,1); add(0,0, 0,0,0,0,1,1);
        add(0,0, 0,0,1,0,1,1); add(0,0, 0,0,0,0,1,1); add(0,0, 1,0,0,0,1,1); add(0,0, 1,0,0,0,1,1);
        add(0,0, 0,0,0,0,1,0); add(0,0, 0,0,0,0,1,0);

        @(negedge clk);
        chk("reset_state", {oOrbit, oRdEn, oFrameStart, oBusy, oGrpOddity, oNumGrp, oAddr}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < n_vec; i++) begin
            iEnable = tbl[i].en;
            iMode   = tbl[i].mode;
            step();
            chk($sformatf("row%0d", i),
                {oOrbit, oFrameStart, oRdEn, oBusy, oNumGrp, oGrpOddity},
                {tbl[i].orb, tbl[i].fs, tbl[i].rd, tbl[i].busy, tbl[i].grp, tbl[i].grp});
            if (tbl[i].rd) chk($sformatf("row%0d_addr", i), oAddr, tbl[i].addr);
        end

        // restart keeps the group index from before IDLE
        iEnable = 1'b1;
        iMode   = 3'd0;
        wait_fs(n);
        chk("restart_latency", n, 3);
        chk("grp_kept", {oNumGrp, oGrpOddity}, 2'b11);

        // mode change mid-frame only applies from the next wrap
        repeat (5) step();
        iMode = 3'd1;
        wait_fs(n);
        chk("frame_len_p1", n + 5, 16);
        chk("grp_wrap", {oNumGrp, oGrpOddity}, 2'b00);
        chk("p2_bit0_c0", oOrbit, 1);
        step();
        chk("p2_bit0_c1", oOrbit, 1);
        step();
        chk("p2_bit1_c0", oOrbit, 0);
        step();
        chk("p2_bit1_c1", oOrbit, 0);
        iMode = 3'd2;
        wait_fs(n);
        chk("frame_len_p2", n + 3, 32);
        chk("grp_third", {oNumGrp, oGrpOddity}, 2'b11);
        iMode = 3'd7;
        wait_fs(n);
        chk("frame_len_p4", n, 64);
        chk("grp_fourth", {oNumGrp, oGrpOddity}, 2'b00);
        wait_fs(n);
        chk("frame_len_p16", n, 256);
        chk("grp_fifth", {oNumGrp, oGrpOddity}, 2'b11);

        iEnable = 1'b0;
        n = 0;
        while (oBusy && n < 600) begin
            step();
            n++;
        end
        chk("stop_busy", oBusy, 0);
        chk("stop_len", n, 256);
        chk("stop_orbit", {oOrbit, oRdEn}, 2'b00);

        // asynchronous reset in the middle of a P=4 bit
        iMode   = 3'd2;
        iEnable = 1'b1;
        repeat (11) step();
        chk("pre_reset_orbit", oOrbit, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", {oOrbit, oRdEn, oFrameStart, oBusy, oGrpOddity, oNumGrp, oAddr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        iMode = 3'd0;
        repeat (3) step();
        chk("post_reset_b0", {oOrbit, oFrameStart, oBusy}, 3'b111);
        step();
        chk("post_reset_b1", oOrbit, 0);
        step();
        chk("post_reset_b2", oOrbit, 1);
        step();
        chk("post_reset_b3", oOrbit, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
